rf_write_arbiter: RTL and testbench

- Shares the single register-file write port (PW/RW/EN) between two writeback requesters: the ALU result path and the load-return path.
- Each requester uses a valid/ready handshake.
- The arbiter chooses one winner per cycle: load-priority, with a starvation limit that guarantees ALU progress.
- The winning write is registered and driven to the register file one cycle after acceptance.

---
 rtl/rf_write_arbiter_if.sv | 31 +++
 rtl/rf_write_arbiter.sv | 80 ++++++++
 tb/tb_rf_write_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Writeback port bundle between the two requesters and the register-file write arbiter.
// Each requester raises VALID with RW/PW and holds all three until a rising edge sees VALID & READY.
interface rf_write_arbiter_if #(
    parameter int CNT_W = 2
);
    logic             ALU_VALID;
    logic [4:0]       ALU_RW;
    logic [31:0]      ALU_PW;
    logic             ALU_READY;
    logic             LD_VALID;
    logic [4:0]       LD_RW;
    logic [31:0]      LD_PW;
    logic             LD_READY;
    logic [31:0]      PW;
    logic [4:0]       RW;
    logic             EN;
    logic             GNT_SRC;
    logic [CNT_W-1:0] ALU_WAIT;

    // Requester / register-file side.
    modport master (
        output ALU_VALID, ALU_RW, ALU_PW, LD_VALID, LD_RW, LD_PW,
        input  ALU_READY, LD_READY, PW, RW, EN, GNT_SRC, ALU_WAIT
    );

    // Arbiter side.
    modport slave (
        input  ALU_VALID, ALU_RW, ALU_PW, LD_VALID, LD_RW, LD_PW,
        output ALU_READY, LD_READY, PW, RW, EN, GNT_SRC, ALU_WAIT
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Load-priority arbiter for the single register-file write port, with an ALU starvation limit.
// The winning write is registered and presented to the register file one cycle after acceptance.
module rf_write_arbiter #(
    parameter int MAX_WAIT = 3,
    parameter int CNT_W    = 2
) (
    input  logic              CLK,
    input  logic              RST,
    rf_write_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    logic             alu_ready;
    logic             ld_ready;
    logic             force_alu;
    logic [CNT_W-1:0] alu_wait;
    logic [31:0]      pw_q;
    logic [4:0]       rw_q;
    logic             en_q;
    logic             gnt_src_q;

    assign force_alu = bus.ALU_VALID && (alu_wait == WAIT_LIMIT);

    // Grant is purely combinational; nothing is accepted while reset is held.
    always_comb begin
        alu_ready = 1'b0;
        ld_ready  = 1'b0;
        if (!RST) begin
            if (force_alu) begin
                alu_ready = 1'b1;
            end else if (bus.LD_VALID) begin
                ld_ready = 1'b1;
            end else if (bus.ALU_VALID) begin
                alu_ready = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            alu_wait <= '0;
        end else if (bus.ALU_VALID && !alu_ready) begin
            if (alu_wait != WAIT_LIMIT) begin
                alu_wait <= alu_wait + 1'b1;
            end
        end else begin
            alu_wait <= '0;
        end
    end

    // R0 writes still move PW/RW/GNT_SRC but never raise EN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pw_q      <= '0;
            rw_q      <= '0;
            en_q      <= 1'b0;
            gnt_src_q <= 1'b0;
        end else if (ld_ready) begin
            pw_q      <= bus.LD_PW;
            rw_q      <= bus.LD_RW;
            en_q      <= (bus.LD_RW != 5'd0);
            gnt_src_q <= 1'b1;
        end else if (alu_ready) begin
            pw_q      <= bus.ALU_PW;
            rw_q      <= bus.ALU_RW;
            en_q      <= (bus.ALU_RW != 5'd0);
            gnt_src_q <= 1'b0;
        end else begin
            en_q      <= 1'b0;
        end
    end

    assign bus.ALU_READY = alu_ready;
    assign bus.LD_READY  = ld_ready;
    assign bus.ALU_WAIT  = alu_wait;
    assign bus.PW        = pw_q;
    assign bus.RW        = rw_q;
    assign bus.EN        = en_q;
    assign bus.GNT_SRC   = gnt_src_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed scenarios for rf_write_arbiter with a cycle-level reference model and write scoreboard.
module tb_rf_write_arbiter;
    localparam int MAX_WAIT = 3;
    localparam int CNT_W    = 2;

    logic CLK;
    logic RST;
    int   errors;
    int   checks;
    bit   mon_on;

    rf_write_arbiter_if #(.CNT_W(CNT_W)) bus ();

    rf_write_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file fed by the DUT write port, to see final contents.
    logic [31:0] rf [32];
    always @(posedge CLK) begin
        if (bus.EN && bus.RW != 5'd0) rf[bus.RW] <= bus.PW;
    end

    // Scoreboard: {GNT_SRC, RW, PW} of every expected EN pulse.
    logic [37:0] exp_q[$];

    // Reference model state (values the DUT should show after the last edge).
    logic [CNT_W-1:0] m_wait;
    logic             m_en;
    logic             m_gnt;
    logic [4:0]       m_rw;
    logic [31:0]      m_pw;

    always @(negedge CLK) begin
        logic e_ar, e_lr;
        logic [37:0] exp_w;
        if (mon_on) begin
            checks++;
            if (bus.EN !== m_en) begin
                errors++;
                $display("FAIL mon_en t=%0t actual=%b required=%b", $time, bus.EN, m_en);
            end
            checks++;
            if ({bus.GNT_SRC, bus.RW, bus.PW} !== {m_gnt, m_rw, m_pw}) begin
                errors++;
                $display("FAIL mon_out t=%0t actual=%0d/%0d/%h required=%0d/%0d/%h",
                         $time, bus.GNT_SRC, bus.RW, bus.PW, m_gnt, m_rw, m_pw);
            end
            if (bus.EN === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected t=%0t actual=%h required=none", $time,
                             {bus.GNT_SRC, bus.RW, bus.PW});
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({bus.GNT_SRC, bus.RW, bus.PW} !== exp_w) begin
                        errors++;
                        $display("FAIL sb_write t=%0t actual=%h required=%h", $time,
                                 {bus.GNT_SRC, bus.RW, bus.PW}, exp_w);
                    end
                end
            end
            checks++;
            if (bus.ALU_WAIT !== m_wait) begin
                errors++;
                $display("FAIL mon_wait t=%0t actual=%0d required=%0d", $time, bus.ALU_WAIT, m_wait);
            end

            e_ar = 1'b0;
            e_lr = 1'b0;
            if (!RST) begin
                if (bus.ALU_VALID && m_wait == CNT_W'(MAX_WAIT)) e_ar = 1'b1;
                else if (bus.LD_VALID) e_lr = 1'b1;
                else if (bus.ALU_VALID) e_ar = 1'b1;
            end
            checks++;
            if ({bus.ALU_READY, bus.LD_READY} !== {e_ar, e_lr}) begin
                errors++;
                $display("FAIL mon_ready t=%0t actual=%b%b required=%b%b", $time,
                         bus.ALU_READY, bus.LD_READY, e_ar, e_lr);
            end

            if (RST) begin
                m_wait = '0; m_en = 1'b0; m_gnt = 1'b0; m_rw = '0; m_pw = '0;
            end else begin
                m_en = 1'b0;
                if (e_lr) begin
                    m_gnt = 1'b1; m_rw = bus.LD_RW; m_pw = bus.LD_PW;
                end else if (e_ar) begin
                    m_gnt = 1'b0; m_rw = bus.ALU_RW; m_pw = bus.ALU_PW;
                end
                if ((e_lr || e_ar) && m_rw != 5'd0) begin
                    m_en = 1'b1;
                    exp_q.push_back({m_gnt, m_rw, m_pw});
                end
                if (bus.ALU_VALID && !e_ar) begin
                    if (m_wait != CNT_W'(MAX_WAIT)) m_wait = m_wait + 1'b1;
                end else begin
                    m_wait = '0;
                end
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [4:0] rw, input logic [31:0] pw);
        bus.ALU_VALID = v; bus.ALU_RW = rw; bus.ALU_PW = pw;
    endtask

    task automatic set_ld(input logic v, input logic [4:0] rw, input logic [31:0] pw);
        bus.LD_VALID = v; bus.LD_RW = rw; bus.LD_PW = pw;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        set_alu(1'b1, 5'd3, 32'h1);
        set_ld(1'b1, 5'd4, 32'h2);
        step();
        mon_on = 1'b1;
        step();
        @(negedge CLK);
        checks++;
        if ({bus.ALU_READY, bus.LD_READY, bus.EN} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready_en actual=%b required=000", {bus.ALU_READY, bus.LD_READY, bus.EN});
        end
        checks++;
        if ({bus.PW, bus.RW, bus.ALU_WAIT} !== '0) begin
            errors++;
            $display("FAIL reset_regs actual=%h/%0d/%0d required=0/0/0", bus.PW, bus.RW, bus.ALU_WAIT);
        end
        step();
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({bus.LD_READY, bus.ALU_READY} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release_ld actual=%b required=10", {bus.LD_READY, bus.ALU_READY});
        end
        step();
        set_ld(1'b0, 5'd0, 32'h0);
        step();
        set_alu(1'b0, 5'd0, 32'h0);
        step();
    endtask

    task automatic test_single();
        set_alu(1'b1, 5'd5, 32'h0000_00AA);
        @(negedge CLK);
        checks++;
        if (bus.ALU_READY !== 1'b1) begin
            errors++;
            $display("FAIL single_alu_ready actual=%b required=1", bus.ALU_READY);
        end
        step();
        set_alu(1'b0, 5'd0, 32'h0);
        @(negedge CLK);
        checks++;
        if ({bus.EN, bus.RW, bus.PW, bus.GNT_SRC} !== {1'b1, 5'd5, 32'h0000_00AA, 1'b0}) begin
            errors++;
            $display("FAIL single_alu_out actual=%b/%0d/%h/%b required=1/5/000000aa/0",
                     bus.EN, bus.RW, bus.PW, bus.GNT_SRC);
        end
        step();
        set_ld(1'b1, 5'd9, 32'hDEAD_BEEF);
        step();
        set_ld(1'b0, 5'd0, 32'h0);
        @(negedge CLK);
        checks++;
        if ({bus.EN, bus.RW, bus.PW, bus.GNT_SRC} !== {1'b1, 5'd9, 32'hDEAD_BEEF, 1'b1}) begin
            errors++;
            $display("FAIL single_ld_out actual=%b/%0d/%h/%b required=1/9/deadbeef/1",
                     bus.EN, bus.RW, bus.PW, bus.GNT_SRC);
        end
        step();
    endtask

    task automatic test_starvation();
        set_alu(1'b1, 5'd12, 32'h55);
        for (int k = 0; k < 5; k++) begin
            if (k != 3) set_ld(1'b1, 5'(16 + k), $urandom_range(1, 32'hFFFF));
            @(negedge CLK);
            checks++;
            if (k < 3) begin
                if ({bus.LD_READY, bus.ALU_READY, bus.ALU_WAIT} !== {1'b1, 1'b0, CNT_W'(k)}) begin
                    errors++;
                    $display("FAIL starve_refuse k=%0d actual=%b%b/%0d required=10/%0d",
                             k, bus.LD_READY, bus.ALU_READY, bus.ALU_WAIT, k);
                end
            end else if (k == 3) begin
                if ({bus.LD_READY, bus.ALU_READY, bus.ALU_WAIT} !== {1'b0, 1'b1, CNT_W'(3)}) begin
                    errors++;
                    $display("FAIL starve_force actual=%b%b/%0d required=01/3",
                             bus.LD_READY, bus.ALU_READY, bus.ALU_WAIT);
                end
            end else begin
                if ({bus.LD_READY, bus.ALU_WAIT} !== {1'b1, CNT_W'(0)}) begin
                    errors++;
                    $display("FAIL starve_resume actual=%b/%0d required=1/0", bus.LD_READY, bus.ALU_WAIT);
                end
            end
            step();
            if (k == 3) set_alu(1'b0, 5'd0, 32'h0);
        end
        set_ld(1'b0, 5'd0, 32'h0);
        step();
    endtask

    task automatic test_r0();
        set_alu(1'b1, 5'd0, 32'hFFFF_FFFF);
        @(negedge CLK);
        checks++;
        if (bus.ALU_READY !== 1'b1) begin
            errors++;
            $display("FAIL r0_ready actual=%b required=1", bus.ALU_READY);
        end
        step();
        set_alu(1'b1, 5'd1, 32'h1234);
        @(negedge CLK);
        checks++;
        if ({bus.EN, bus.RW, bus.PW} !== {1'b0, 5'd0, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL r0_no_write actual=%b/%0d/%h required=0/0/ffffffff", bus.EN, bus.RW, bus.PW);
        end
        step();
        set_alu(1'b0, 5'd0, 32'h0);
        @(negedge CLK);
        checks++;
        if ({bus.EN, bus.RW, bus.PW} !== {1'b1, 5'd1, 32'h1234}) begin
            errors++;
            $display("FAIL r0_next_write actual=%b/%0d/%h required=1/1/00001234", bus.EN, bus.RW, bus.PW);
        end
        step();
    endtask

    task automatic test_collision();
        set_alu(1'b1, 5'd7, 32'h22);
        set_ld(1'b1, 5'd7, 32'h11);
        step();
        set_ld(1'b0, 5'd0, 32'h0);
        @(negedge CLK);
        checks++;
        if ({bus.EN, bus.GNT_SRC, bus.PW} !== {1'b1, 1'b1, 32'h11}) begin
            errors++;
            $display("FAIL coll_first actual=%b/%b/%h required=1/1/00000011", bus.EN, bus.GNT_SRC, bus.PW);
        end
        step();
        set_alu(1'b0, 5'd0, 32'h0);
        @(negedge CLK);
        checks++;
        if ({bus.EN, bus.GNT_SRC, bus.PW} !== {1'b1, 1'b0, 32'h22}) begin
            errors++;
            $display("FAIL coll_second actual=%b/%b/%h required=1/0/00000022", bus.EN, bus.GNT_SRC, bus.PW);
        end
        step();
        @(negedge CLK);
        checks++;
        if (rf[7] !== 32'h22) begin
            errors++;
            $display("FAIL coll_rf7 actual=%h required=00000022", rf[7]);
        end
    endtask

    task automatic test_reset_mid();
        step();
        set_alu(1'b1, 5'd20, 32'hA0A0);
        set_ld(1'b1, 5'd21, 32'hB1B1);
        step();
        set_ld(1'b1, 5'd22, 32'hC2C2);
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.LD_READY !== 1'b0) begin
            errors++;
            $display("FAIL mid_ld_blocked actual=%b required=0", bus.LD_READY);
        end
        step();
        RST = 1'b0;
        set_ld(1'b0, 5'd0, 32'h0);
        @(negedge CLK);
        checks++;
        if ({bus.EN, bus.ALU_WAIT, bus.ALU_READY} !== {1'b0, CNT_W'(0), 1'b1}) begin
            errors++;
            $display("FAIL mid_rearb actual=%b/%0d/%b required=0/0/1", bus.EN, bus.ALU_WAIT, bus.ALU_READY);
        end
        step();
        set_alu(1'b0, 5'd0, 32'h0);
        @(negedge CLK);
        checks++;
        if ({bus.EN, bus.RW, bus.PW} !== {1'b1, 5'd20, 32'hA0A0}) begin
            errors++;
            $display("FAIL mid_alu_write actual=%b/%0d/%h required=1/20/0000a0a0", bus.EN, bus.RW, bus.PW);
        end
        step();
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        mon_on = 1'b0;
        m_wait = '0; m_en = 1'b0; m_gnt = 1'b0; m_rw = '0; m_pw = '0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        RST = 1'b1;
        set_alu(1'b0, 5'd0, 32'h0);
        set_ld(1'b0, 5'd0, 32'h0);
        test_reset();
        test_single();
        test_starvation();
        test_r0();
        test_collision();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover actual=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
